// File: rtl/ucode_sequencer_pkg.sv
// Shared definitions for the SCAMP microcode sequencer: microinstruction field positions,
// bus codes used by the control logic, sequencer state encoding and the decoded-strobe bundle.
package ucode_sequencer_pkg;

    localparam int UI_W = 16;

    // With eo_bar=1 the ALU field is reused for bus_out and the rt/pp bits.
    localparam int EO_BIT     = 15;
    localparam int ALU_HI     = 14;
    localparam int ALU_LO     = 9;
    localparam int BUS_OUT_HI = 14;
    localparam int BUS_OUT_LO = 12;
    localparam int RT_BIT     = 11;
    localparam int PP_BIT     = 10;
    localparam int CE_BIT     = 8;
    localparam int BUS_IN_HI  = 7;
    localparam int BUS_IN_LO  = 5;
    localparam int JZ_BIT     = 4;
    localparam int JGT_BIT    = 3;
    localparam int JLT_BIT    = 2;
    localparam int JC_BIT     = 1;

    localparam logic [2:0] OUT_DO  = 3'd6;
    localparam logic [2:0] IN_NONE = 3'd0;
    localparam logic [2:0] IN_DI   = 3'd6;

    localparam logic [7:0] SEL_IDLE  = 8'hFF;
    localparam logic [7:0] LOAD_MASK = 8'h3E;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic       eo_bar;
        logic [5:0] alu_flags;
        logic       ce;
        logic [2:0] bus_out;
        logic [7:0] out_sel_bar;
        logic [7:0] in_sel_bar;
        logic       rt;
        logic       pp;
        logic       jz;
        logic       jgt;
        logic       jlt;
        logic       jc;
    } ucode_ctrl_t;

    function automatic logic [7:0] sel_low(input logic [2:0] code);
        sel_low = ~(8'd1 << code);
    endfunction

endpackage

// File: rtl/ucode_sequencer_if.sv
// Sequencer-to-datapath connection: ROM address/data, device handshake and all decoded strobes.
// master = the sequencer, slave = the IR/ROM/datapath side.
interface ucode_sequencer_if #(
    parameter int OPC_W = 8,
    parameter int T_W   = 3
);
    logic [OPC_W-1:0]     opcode;
    logic [OPC_W+T_W-1:0] rom_addr;
    logic [15:0]          rom_data;
    logic                 dev_ready;
    logic [T_W-1:0]       tstate;
    logic                 eo_bar;
    logic [5:0]           alu_flags;
    logic                 ce;
    logic [7:0]           out_sel_bar;
    logic [7:0]           in_sel_bar;
    logic                 rt;
    logic                 pp;
    logic                 jz;
    logic                 jgt;
    logic                 jlt;
    logic                 jc;
    logic                 halted;
    logic                 waiting;
    logic                 bus_err;

    modport master (
        input  opcode, rom_data, dev_ready,
        output rom_addr, tstate, eo_bar, alu_flags, ce, out_sel_bar, in_sel_bar,
        output rt, pp, jz, jgt, jlt, jc, halted, waiting, bus_err
    );

    modport slave (
        output opcode, rom_data, dev_ready,
        input  rom_addr, tstate, eo_bar, alu_flags, ce, out_sel_bar, in_sel_bar,
        input  rt, pp, jz, jgt, jlt, jc, halted, waiting, bus_err
    );
endinterface

// File: rtl/ucode_field_decode.sv
// Pure combinational microinstruction decode into active-low bus selects, ALU flags and jumps.
// No state or gating here; the sequencer applies halt/wait suppression on top.
module ucode_field_decode
    import ucode_sequencer_pkg::*;
(
    input  logic [UI_W-1:0] i_uinstr,
    output ucode_ctrl_t     o_ctrl
);
    logic [2:0] w_bus_in;
    logic       w_unused_bit0;

    assign w_bus_in      = i_uinstr[BUS_IN_HI:BUS_IN_LO];
    assign w_unused_bit0 = i_uinstr[0];

    // NOTE: every field gets a default first so no path through always_comb can infer a latch.
    always_comb begin
        o_ctrl             = '0;
        o_ctrl.eo_bar      = i_uinstr[EO_BIT];
        o_ctrl.alu_flags   = i_uinstr[ALU_HI:ALU_LO];
        o_ctrl.ce          = i_uinstr[CE_BIT];
        o_ctrl.bus_out     = i_uinstr[BUS_OUT_HI:BUS_OUT_LO];
        o_ctrl.out_sel_bar = i_uinstr[EO_BIT] ? sel_low(o_ctrl.bus_out) : SEL_IDLE;
        o_ctrl.in_sel_bar  = (w_bus_in == IN_NONE) ? SEL_IDLE : sel_low(w_bus_in);
        o_ctrl.rt          = i_uinstr[EO_BIT] & i_uinstr[RT_BIT];
        o_ctrl.pp          = i_uinstr[EO_BIT] & i_uinstr[PP_BIT];
        o_ctrl.jz          = i_uinstr[JZ_BIT];
        o_ctrl.jgt         = i_uinstr[JGT_BIT];
        o_ctrl.jlt         = i_uinstr[JLT_BIT];
        o_ctrl.jc          = i_uinstr[JC_BIT];
    end
endmodule

// File: rtl/ucode_sequencer.sv
// SCAMP microcode sequencer: T-state counter, ROM addressing, halt and device-wait stalls.
// Define UCODE_DEV_WAIT_EN to enable the WAIT state, its timeout and bus_err.
module ucode_sequencer
    import ucode_sequencer_pkg::*;
#(
    parameter int OPC_W     = 8,
    parameter int T_W       = 3,
    parameter int NSTEPS    = 8,
    parameter int HALT_CODE = 7,
    parameter int WAIT_MAX  = 255
) (
    input  logic            clk,
    input  logic            reset_bar,
    ucode_sequencer_if.master bus
);
`ifdef UCODE_DEV_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam int             CNT_W     = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [T_W-1:0] LAST_STEP = T_W'(NSTEPS - 1);
    localparam logic [2:0]     HALT_SEL  = 3'(HALT_CODE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    seq_state_e           r_state;
    logic [T_W-1:0]       r_tstate;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 r_bus_err;

    ucode_ctrl_t          w_raw;
    ucode_ctrl_t          w_ctrl;
    logic                 w_dev_strobe;
    logic                 w_timeout;
    logic                 w_halt_req;
    logic                 w_stall;
    logic [OPC_W+T_W-1:0] w_rom_addr;

    ucode_field_decode u_decode (
        .i_uinstr (bus.rom_data),
        .o_ctrl   (w_raw)
    );

    assign w_rom_addr   = {bus.opcode, r_tstate};
    assign w_dev_strobe = !w_raw.out_sel_bar[OUT_DO] || !w_raw.in_sel_bar[IN_DI];
    assign w_timeout    = (r_state == ST_WAIT) && (r_wait_cnt >= CNT_MAX);
    assign w_halt_req   = (r_state != ST_HALT) && w_raw.eo_bar && (w_raw.bus_out == HALT_SEL);

    // The stall is visible in the very cycle the device strobe meets dev_ready=0.
    assign w_stall = WAIT_EN && (r_state != ST_HALT) && w_dev_strobe && !bus.dev_ready && !w_timeout;

    always_comb begin
        w_ctrl = w_raw;
        if (r_state == ST_HALT) begin
            w_ctrl.eo_bar      = 1'b1;
            w_ctrl.ce          = 1'b0;
            w_ctrl.out_sel_bar = SEL_IDLE;
            w_ctrl.in_sel_bar  = SEL_IDLE;
            w_ctrl.rt          = 1'b0;
            w_ctrl.pp          = 1'b0;
            {w_ctrl.jz, w_ctrl.jgt, w_ctrl.jlt, w_ctrl.jc} = 4'b0000;
        end else if (w_stall) begin
            // Device strobe and bus source stay live; only register loads and sequencing are held.
            w_ctrl.in_sel_bar  = w_raw.in_sel_bar | LOAD_MASK;
            w_ctrl.rt          = 1'b0;
            w_ctrl.pp          = 1'b0;
            {w_ctrl.jz, w_ctrl.jgt, w_ctrl.jlt, w_ctrl.jc} = 4'b0000;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            r_state    <= ST_RUN;
            r_tstate   <= '0;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_WAIT: begin
                    if (w_halt_req) begin
                        r_state    <= ST_HALT;
                        r_wait_cnt <= '0;
                    end else if (w_stall) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                        if (w_timeout && w_dev_strobe && !bus.dev_ready) begin
                            r_bus_err <= 1'b1;
                        end
                        r_tstate <= (w_raw.rt || r_tstate == LAST_STEP) ? '0 : r_tstate + T_W'(1);
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.rom_addr    = w_rom_addr;
    assign bus.tstate      = r_tstate;
    assign bus.eo_bar      = w_ctrl.eo_bar;
    assign bus.alu_flags   = w_ctrl.alu_flags;
    assign bus.ce          = w_ctrl.ce;
    assign bus.out_sel_bar = w_ctrl.out_sel_bar;
    assign bus.in_sel_bar  = w_ctrl.in_sel_bar;
    assign bus.rt          = w_ctrl.rt;
    assign bus.pp          = w_ctrl.pp;
    assign bus.jz          = w_ctrl.jz;
    assign bus.jgt         = w_ctrl.jgt;
    assign bus.jlt         = w_ctrl.jlt;
    assign bus.jc          = w_ctrl.jc;
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.waiting     = w_stall;
    assign bus.bus_err     = r_bus_err;
endmodule
